// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Owns the single register-file write port. Three writers compete for it:
//   - WB  : in-order pipeline writeback (highest priority, can be stalled)
//   - DIV : multicycle divider result   (long-latency, valid/ready)
//   - MEM : load-return path            (long-latency, valid/ready)
// WB normally wins. A long requester that keeps losing to WB is protected by
// a starvation counter: after STARVE_LIMIT consecutive losses the long
// requester is forced through and WB is stalled for that cycle. DIV and MEM
// share the long slot round-robin.
//
// The block also keeps a 32-entry pending scoreboard of destinations owned by
// in-flight long-latency ops so decode can stall on RAW hazards.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wb_we/wb_waddr/wb_wdata     pipeline writeback request
//   wb_stall                    WB must hold; its write is not performed
//   div_valid/waddr/wdata       divider result, div_ready = accepted
//   mem_valid/waddr/wdata       load return,   mem_ready = accepted
//   issue_valid/issue_waddr     long-latency op issued, marks dest pending
//   chk_raddr1/chk_raddr2       decode sources, chk_busy = a source pending
//   rf_we/rf_waddr/rf_wdata     register-file write port
//
// Parameters:
//   STARVE_LIMIT  consecutive losses to WB tolerated by a valid long
//                 requester before WB is stalled for one cycle (1..15)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        wb_stall,

    input  logic        div_valid,
    input  logic [4:0]  div_waddr,
    input  logic [31:0] div_wdata,
    output logic        div_ready,

    input  logic        mem_valid,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,

    input  logic        issue_valid,
    input  logic [4:0]  issue_waddr,

    input  logic [4:0]  chk_raddr1,
    input  logic [4:0]  chk_raddr2,
    output logic        chk_busy,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_DIV,
        GRANT_MEM
    } grant_e;

    // State
    logic [31:0] pending;
    logic [3:0]  starve_cnt;
    logic        rr_last;        // 0: DIV granted last, 1: MEM granted last

    // Arbitration signals
    logic        wb_req;
    logic        long_req;
    logic        starved;
    grant_e      long_pick;
    grant_e      grant;
    logic        long_grant;
    logic [4:0]  long_waddr;

    // Scoreboard next-state
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] pending_next;

    // -------------------------------------------------------------------------
    // Request qualification and winner selection
    // -------------------------------------------------------------------------
    // A WB write to r0 is architecturally a no-op, so it does not compete for
    // the port and does not count as a loss for the long requesters.
    assign wb_req   = wb_we && (wb_waddr != 5'd0);
    assign long_req = div_valid || mem_valid;
    assign starved  = long_req && (starve_cnt == STARVE_MAX);

    // NOTE: every signal written in an always_comb block gets a default
    // assignment first so no path through the block can leave it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        long_pick = GRANT_DIV;
        if (div_valid && mem_valid) begin
            // Round-robin: whoever did not win the last long grant goes now.
            long_pick = rr_last ? GRANT_DIV : GRANT_MEM;
        end else if (mem_valid) begin
            long_pick = GRANT_MEM;
        end
    end

    always_comb begin
        grant = GRANT_NONE;
        // Requests seen while reset is asserted are dropped: no ready, no
        // write. Owners re-present them once reset is released.
        if (!rst_n) begin
            grant = GRANT_NONE;
        end else if (starved) begin
            grant = long_pick;
        end else if (wb_req) begin
            grant = GRANT_WB;
        end else if (long_req) begin
            grant = long_pick;
        end
    end

    assign long_grant = (grant == GRANT_DIV) || (grant == GRANT_MEM);
    assign long_waddr = (grant == GRANT_MEM) ? mem_waddr : div_waddr;

    // -------------------------------------------------------------------------
    // Grant outputs
    // -------------------------------------------------------------------------
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        div_ready = 1'b0;
        mem_ready = 1'b0;
        unique case (grant)
            GRANT_WB: begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end
            GRANT_DIV: begin
                // A result for r0 is still consumed (ready) but never written.
                div_ready = 1'b1;
                rf_we     = (div_waddr != 5'd0);
                rf_waddr  = div_waddr;
                rf_wdata  = div_wdata;
            end
            GRANT_MEM: begin
                mem_ready = 1'b1;
                rf_we     = (mem_waddr != 5'd0);
                rf_waddr  = mem_waddr;
                rf_wdata  = mem_wdata;
            end
            default: ;
        endcase
    end

    // WB is only stalled when it actually had a write that lost the port.
    assign wb_stall = rst_n && starved && wb_req;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_valid && (issue_waddr != 5'd0)) begin
            set_mask[issue_waddr] = 1'b1;
        end
        if (long_grant) begin
            clr_mask[long_waddr] = 1'b1;
        end
        // Set is applied after clear: a fresh issue to the same register
        // supersedes the result that is retiring this cycle.
        pending_next = (pending & ~clr_mask) | set_mask;
    end

    // Bit 0 of pending is never set, but the explicit r0 tests keep the intent
    // obvious and independent of that invariant.
    assign chk_busy = rst_n &&
                      (((chk_raddr1 != 5'd0) && pending[chk_raddr1]) ||
                       ((chk_raddr2 != 5'd0) && pending[chk_raddr2]));

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the pending array is a bank of flops, not a RAM, so it is cleared
    // by reset like any other control state; a stale bit after reset would
    // stall decode forever on a register nobody will write.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 32'd0;
            starve_cnt <= 4'd0;
            rr_last    <= 1'b0;
        end else begin
            pending <= pending_next;
            if (long_grant) begin
                rr_last    <= (grant == GRANT_MEM);
                starve_cnt <= 4'd0;
            end else if (long_req) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

endmodule
